// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, synchronous-RAM fetch, skid-buffered decode handshake.
// Optional FETCH_CTRL_ALIGN_CHECK_EN rejects misaligned redirects and pulses misalign.
module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [5:0]  imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] PC_new,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_code,
    output logic [31:0] inst_pc,
    output logic        misalign
);

    typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

    state_e      state_q, state_d;
    logic        rst_sync_q;
    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_code_q, skid_code_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        out_valid_q, out_valid_d;
    logic        out_live_q, out_live_d;
    logic [31:0] out_code_q, out_code_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        misalign_q, misalign_d;

    logic        redir_take;
    logic        redir_bad;
    logic [31:0] redir_target;
    logic        out_free;
    logic        issue;

`ifdef FETCH_CTRL_ALIGN_CHECK_EN
    assign redir_take = redirect && (redirect_pc[1:0] == 2'b00);
    assign redir_bad  = redirect && (redirect_pc[1:0] != 2'b00);
`else
    assign redir_take = redirect;
    assign redir_bad  = 1'b0;
`endif
    assign redir_target = redirect_pc & 32'hFFFF_FFFC;

    assign PC         = pc_q;
    assign PC_new     = pc_q + 32'd4;
    assign imem_addr  = pc_q[7:2];
    assign inst_valid = out_valid_q;
    // A live output entry is the read issued last cycle, shown straight from the RAM port.
    assign inst_code  = out_live_q ? imem_rdata : out_code_q;
    assign inst_pc    = out_pc_q;
    assign misalign   = misalign_q;

    assign out_free = !out_valid_q || inst_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        pend_pc_d    = pend_pc_q;
        skid_valid_d = skid_valid_q;
        skid_code_d  = skid_code_q;
        skid_pc_d    = skid_pc_q;
        out_valid_d  = out_valid_q;
        out_live_d   = out_live_q;
        out_code_d   = out_code_q;
        out_pc_d     = out_pc_q;
        misalign_d   = 1'b0;
        issue        = 1'b0;

        // rst_sync_q low holds BOOT until the first full cycle after reset release.
        if (rst_sync_q) begin
            misalign_d = redir_bad;
            unique case (state_q)
                StBoot:  issue = 1'b1;
                StRun:   issue = out_free || !pend_q;
                default: issue = 1'b0;
            endcase

            if (redir_take) begin
                state_d      = StRun;
                pc_d         = redir_target;
                pend_d       = 1'b0;
                skid_valid_d = 1'b0;
                out_valid_d  = 1'b0;
                out_live_d   = 1'b0;
            end else begin
                if (state_q == StBoot) begin
                    state_d = StRun;
                end
                if (issue) begin
                    pc_d = PC_new;
                end

                if (out_free) begin
                    if (skid_valid_q) begin
                        out_valid_d  = 1'b1;
                        out_live_d   = 1'b0;
                        out_code_d   = skid_code_q;
                        out_pc_d     = skid_pc_q;
                        skid_valid_d = 1'b0;
                        state_d      = StRun;
                    end else if (pend_q) begin
                        out_valid_d = 1'b1;
                        out_live_d  = 1'b0;
                        out_code_d  = imem_rdata;
                        out_pc_d    = pend_pc_q;
                        pend_d      = issue;
                        pend_pc_d   = pc_q;
                    end else if (issue) begin
                        out_valid_d = 1'b1;
                        out_live_d  = 1'b1;
                        out_pc_d    = pc_q;
                    end else begin
                        out_valid_d = 1'b0;
                        out_live_d  = 1'b0;
                    end
                end else begin
                    // Stalled: freeze a live entry before the RAM port moves on.
                    if (out_live_q) begin
                        out_code_d = imem_rdata;
                        out_live_d = 1'b0;
                    end
                    if (pend_q) begin
                        skid_valid_d = 1'b1;
                        skid_code_d  = imem_rdata;
                        skid_pc_d    = pend_pc_q;
                        pend_d       = 1'b0;
                        state_d      = StHold;
                    end else if (issue) begin
                        pend_d    = 1'b1;
                        pend_pc_d = pc_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q   <= 1'b0;
            state_q      <= StBoot;
            pc_q         <= RESET_VECTOR;
            pend_q       <= 1'b0;
            pend_pc_q    <= 32'd0;
            skid_valid_q <= 1'b0;
            skid_code_q  <= 32'd0;
            skid_pc_q    <= 32'd0;
            out_valid_q  <= 1'b0;
            out_live_q   <= 1'b0;
            out_code_q   <= 32'd0;
            out_pc_q     <= 32'd0;
            misalign_q   <= 1'b0;
        end else begin
            rst_sync_q   <= 1'b1;
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_pc_q    <= pend_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_code_q  <= skid_code_d;
            skid_pc_q    <= skid_pc_d;
            out_valid_q  <= out_valid_d;
            out_live_q   <= out_live_d;
            out_code_q   <= out_code_d;
            out_pc_q     <= out_pc_d;
            misalign_q   <= misalign_d;
        end
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h00000000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port redirect  input  1  branch/jump taken, sampled on the clk rising edge.
REQ-005 SHALL have port redirect_pc  input  32  redirect target address.
REQ-006 SHALL have port imem_addr  output  6  instruction RAM word address, equal to PC[7:2] combinationally.
REQ-007 SHALL have port imem_rdata  input  32  instruction RAM read data, valid one cycle after imem_addr.
REQ-008 SHALL have port PC  output  32  current fetch address register.
REQ-009 SHALL have port PC_new  output  32  PC+4 combinational.
REQ-010 SHALL have ports inst_valid (output, 1), inst_ready (input, 1), inst_code (output, 32) and inst_pc (output, 32): the decode handshake, instruction word and its address.
REQ-011 SHALL have port misalign  output  1  one-cycle pulse flagging a rejected misaligned redirect.

Function
REQ-012 SHALL implement FSM states BOOT, RUN and HOLD.
REQ-013 BOOT: entered on reset; issues a read at RESET_VECTOR; next cycle PC<=RESET_VECTOR+4, state->RUN.
REQ-014 RUN: every cycle issues a read at PC; PC<=PC_new; the previous cycle's read data goes to the output register with inst_pc = its issue address.
REQ-015 Output register SHALL load only when inst_valid==0 or inst_ready==1; a transfer occurs when inst_valid&&inst_ready.
REQ-016 If the output register is full and inst_ready==0 while a read returns, data SHALL go to a one-entry skid buffer; state->HOLD; PC and imem_addr hold.
REQ-017 HOLD: no new read issued; when inst_ready==1, output register loads the skid entry, skid empties, state->RUN, and issue resumes the next cycle at the held PC.
REQ-018 No instruction SHALL be dropped, duplicated or reordered absent redirect.
REQ-019 Redirect SHALL have priority over stall and HOLD: at T+1 PC=redirect_pc, skid and in-flight read squashed, inst_valid=0, state=RUN.
REQ-020 After redirect at T, the first valid instruction SHALL appear at T+2 with inst_pc=redirect_pc (redirect-to-valid latency 2).
REQ-021 Redirect and inst_ready high in the same cycle: current output transfer completes; nothing else from the old path is delivered.
REQ-022 PC arithmetic SHALL be modulo 2^32: 32'hFFFFFFFC -> 32'h00000000; imem_addr wraps 63 -> 0.
REQ-023 inst_code/inst_pc SHALL hold stable while inst_valid&&!inst_ready.

Reset
REQ-024 Reset assertion SHALL immediately force: state=BOOT, PC=RESET_VECTOR, inst_valid=0, inst_code=0, inst_pc=0, skid empty, misalign=0.
REQ-025 Reset mid-operation SHALL discard all in-flight and buffered instructions; deassertion is synchronized so that BOOT lasts exactly one clk cycle.

Configuration
REQ-026 Macro FETCH_CTRL_ALIGN_CHECK_EN: when defined, redirect with redirect_pc[1:0]!=0 SHALL be ignored (PC, pipeline untouched) and misalign SHALL pulse high for one cycle at T+1.
REQ-027 Without FETCH_CTRL_ALIGN_CHECK_EN, misalign SHALL be tied 0 and redirect_pc[1:0] SHALL be treated as 2'b00.

Verification
REQ-028 Reset release, inst_ready=1, RAM word n = n -> inst_pc 0,4,8,... with inst_code 0,1,2,... one per cycle from cycle 2.
REQ-029 inst_ready=0 for 3 cycles mid-stream -> inst_valid held, inst_code stable, HOLD entered, PC held; on release next inst_pc increments by 4, no gaps/duplicates.
REQ-030 redirect=1, redirect_pc=32'h40 while in HOLD -> T+1 inst_valid=0, PC=32'h40; T+2 inst_pc=32'h40, inst_code=RAM[16].
REQ-031 RESET_VECTOR=32'hFFFFFFF8 -> inst_pc sequence FFFFFFF8, FFFFFFFC, 00000000; imem_addr 62,63,0.
REQ-032 With FETCH_CTRL_ALIGN_CHECK_EN, redirect_pc=32'h42 -> misalign=1 for one cycle, sequential fetch unaffected; without macro, same stimulus -> PC=32'h40.
REQ-033 Reset asserted asynchronously mid-stream with inst_valid=1 -> outputs clear before next clk edge; first post-reset inst_pc=RESET_VECTOR.
